alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: 1-cycle ADD/SUB/NAND/XOR, bit-serial SLL/SRA/ROR; ALU_SAT_EN enables ADD/SUB saturation.
// Latency: result registered at the accepting edge for 1-cycle ops; shifts finish shamt edges after acceptance.
// Backpressure: in_ready is low while a multi-cycle shift is in progress; no output stall.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [1:0]       sop, sop_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             out_valid_nxt, flag_n_nxt, flag_z_nxt, flag_v_nxt;
  logic [WIDTH-1:0] arith_raw, arith_res, shifted;
  logic             arith_ovf;
  logic [SHW-1:0]   shamt;

  assign in_ready = (state == IDLE);
  assign shamt    = b[SHW-1:0];

  always_comb begin
    arith_raw = opcode[0] ? (a - b) : (a + b);
    // Overflow when the result sign disagrees with a and the effective operand signs match.
    if (opcode[0])
      arith_ovf = (a[MSB] != b[MSB]) && (arith_raw[MSB] != a[MSB]);
    else
      arith_ovf = (a[MSB] == b[MSB]) && (arith_raw[MSB] != a[MSB]);
`ifdef ALU_SAT_EN
    if (arith_ovf)
      arith_res = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      arith_res = arith_raw;
`else
    arith_res = arith_raw;
`endif
  end

  // sop holds opcode[1:0] of the shift: 00 SLL, 01 SRA, 10 ROR.
  always_comb begin
    case (sop)
      2'b00:   shifted = {work[MSB-1:0], 1'b0};
      2'b01:   shifted = {work[MSB], work[MSB:1]};
      2'b10:   shifted = {work[0], work[MSB:1]};
      default: shifted = work;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    work_nxt      = work;
    cnt_nxt       = cnt;
    sop_nxt       = sop;
    result_nxt    = result;
    flag_n_nxt    = flag_n;
    flag_z_nxt    = flag_z;
    flag_v_nxt    = flag_v;
    out_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              result_nxt    = arith_res;
              flag_n_nxt    = arith_res[MSB];
              flag_z_nxt    = (arith_res == '0);
              flag_v_nxt    = arith_ovf;
              out_valid_nxt = 1'b1;
            end
            OP_NAND, OP_XOR: begin
              result_nxt    = opcode[0] ? (a ^ b) : ~(a & b);
              flag_z_nxt    = (result_nxt == '0);
              out_valid_nxt = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
              if (shamt == '0) begin
                result_nxt    = a;
                flag_z_nxt    = (a == '0);
                out_valid_nxt = 1'b1;
              end else begin
                work_nxt  = a;
                cnt_nxt   = shamt;
                sop_nxt   = opcode[1:0];
                state_nxt = SHIFT;
              end
            end
            default: begin
              result_nxt    = '0;
              flag_z_nxt    = 1'b1;
              out_valid_nxt = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        work_nxt = shifted;
        cnt_nxt  = cnt - 1'b1;
        if (cnt == SHW'(1)) begin
          result_nxt    = shifted;
          flag_z_nxt    = (shifted == '0);
          out_valid_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      sop       <= '0;
      result    <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      cnt       <= cnt_nxt;
      sop       <= sop_nxt;
      result    <= result_nxt;
      flag_n    <= flag_n_nxt;
      flag_z    <= flag_z_nxt;
      flag_v    <= flag_v_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;
  localparam int W   = 16;
  localparam int SHW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic [W-1:0] result;
  logic         flag_n, flag_z, flag_v;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_res;
  logic         exp_n, exp_z, exp_v;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  // Reference model: updates expected result/flags and gives the edge count to completion.
  task automatic model(input logic [2:0] op, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       output int edges);
    int sa, sb, s, sh;
    logic [W-1:0] r;
    logic ovf;
    sh = int'(op_b[SHW-1:0]);
    edges = 0;
    if (op == 3'b000 || op == 3'b001) begin
      sa = $signed(op_a);
      sb = $signed(op_b);
      s  = (op == 3'b000) ? sa + sb : sa - sb;
      ovf = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
      r = W'(s);
`ifdef ALU_SAT_EN
      if (ovf) r = (s > 0) ? W'((2**(W-1)) - 1) : W'(-(2**(W-1)));
`endif
      exp_res = r;
      exp_n   = r[W-1];
      exp_z   = (r == '0);
      exp_v   = ovf;
    end else begin
      case (op)
        3'b010:  r = ~(op_a & op_b);
        3'b011:  r = op_a ^ op_b;
        3'b100:  begin r = op_a << sh; edges = sh; end
        3'b101:  begin r = W'($signed(op_a) >>> sh); edges = sh; end
        3'b110:  begin r = (sh == 0) ? op_a : ((op_a >> sh) | (op_a << (W - sh))); edges = sh; end
        default: r = '0;
      endcase
      exp_res = r;
      exp_z   = (r == '0);
    end
  endtask

  // Issues one request at posedge+1 and waits (bounded) for out_valid; edges counts after the accepting edge.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       output int edges, output int low_cnt);
    opcode = op; a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    low_cnt = 0;
    while (!out_valid && edges < 64) begin
      if (!in_ready) low_cnt++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; a = '0; b = '0;
    #3;
    n_tests++;
    if ({result, flag_n, flag_z, flag_v, out_valid, in_ready} !== {{W{1'b0}}, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got res=%h n%b z%b v%b ov%b rdy%b, want 0000 0 0 0 0 1",
               result, flag_n, flag_z, flag_v, out_valid, in_ready);
    end
    exp_res = '0; exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_ovf();
    int e, lo, ee;
    logic [W-1:0] want;
`ifdef ALU_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'h8000;
`endif
    model(3'b000, 16'h7FFF, 16'h0001, ee);
    do_op(3'b000, 16'h7FFF, 16'h0001, e, lo);
    n_tests++;
    if (result !== want || result !== exp_res) begin
      n_fail++; $display("FAIL add_ovf_result: got %h want %h", result, want);
    end
    n_tests++;
    if ({flag_n, flag_v} !== {exp_n, 1'b1} || e !== ee) begin
      n_fail++; $display("FAIL add_ovf_flags: got n%b v%b edges %0d want n%b v1 edges %0d",
                         flag_n, flag_v, e, exp_n, ee);
    end
  endtask

  task automatic test_sub_xor();
    int e, lo, ee;
    model(3'b001, 16'h1234, 16'h1234, ee);
    do_op(3'b001, 16'h1234, 16'h1234, e, lo);
    n_tests++;
    if ({result, flag_z, flag_n, flag_v} !== {16'h0000, 3'b100}) begin
      n_fail++; $display("FAIL sub_zero: got res=%h z%b n%b v%b want 0000 z1 n0 v0",
                         result, flag_z, flag_n, flag_v);
    end
    model(3'b011, 16'hFFFF, 16'h0F0F, ee);
    do_op(3'b011, 16'hFFFF, 16'h0F0F, e, lo);
    n_tests++;
    if ({result, flag_z, flag_n, flag_v} !== {16'hF0F0, 3'b000} || result !== exp_res) begin
      n_fail++; $display("FAIL xor_hold: got res=%h z%b n%b v%b want f0f0 z0 n0 v0",
                         result, flag_z, flag_n, flag_v);
    end
  endtask

  task automatic test_sra_latency();
    int e, lo, ee;
    model(3'b101, 16'h8000, 16'h0004, ee);
    do_op(3'b101, 16'h8000, 16'h0004, e, lo);
    n_tests++;
    if (e !== 4 || lo !== 4) begin
      n_fail++; $display("FAIL sra_latency: got edges %0d ready_low %0d want 4 4", e, lo);
    end
    n_tests++;
    if (result !== 16'hF800 || result !== exp_res) begin
      n_fail++; $display("FAIL sra_result: got %h want f800", result);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL sra_pulse: got ov%b rdy%b want ov0 rdy1", out_valid, in_ready);
    end
  endtask

  task automatic test_ror_sll();
    int e, lo, ee;
    model(3'b110, 16'h0001, 16'h0001, ee);
    do_op(3'b110, 16'h0001, 16'h0001, e, lo);
    n_tests++;
    if (result !== 16'h8000 || e !== 1) begin
      n_fail++; $display("FAIL ror_1: got res=%h edges %0d want 8000 1", result, e);
    end
    model(3'b100, 16'h0001, 16'h0000, ee);
    do_op(3'b100, 16'h0001, 16'h0000, e, lo);
    n_tests++;
    if (result !== 16'h0001 || e !== 0 || lo !== 0) begin
      n_fail++; $display("FAIL sll_0: got res=%h edges %0d low %0d want 0001 0 0", result, e, lo);
    end
  endtask

  task automatic test_reset_during_shift();
    int e, lo, ee, seen;
    seen = 0;
    opcode = 3'b100; a = 16'h0001; b = 16'h000F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({result, flag_n, flag_z, flag_v, out_valid, in_ready} !== {{W{1'b0}}, 4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL abort_reset_state: got res=%h n%b z%b v%b ov%b rdy%b want 0 0 0 0 0 1",
                         result, flag_n, flag_z, flag_v, out_valid, in_ready);
    end
    exp_res = '0; exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen !== 0 || in_ready !== 1'b1 || result !== '0) begin
      n_fail++; $display("FAIL abort_no_pulse: got pulses %0d rdy%b res=%h want 0 1 0000", seen, in_ready, result);
    end
    model(3'b000, 16'd2, 16'd3, ee);
    do_op(3'b000, 16'd2, 16'd3, e, lo);
    n_tests++;
    if (result !== 16'd5 || result !== exp_res || e !== 0) begin
      n_fail++; $display("FAIL add_after_abort: got %h edges %0d want 0005 0", result, e);
    end
  endtask

  task automatic test_back_to_back();
    int ee, pulses;
    logic [2:0] op;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 1) ? 3'b010 : 3'b000;
      opcode = op; a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      model(op, a, b, ee);
      @(posedge clk); #1;
      if (out_valid) pulses++;
      n_tests++;
      if (result !== exp_res || {flag_n, flag_z, flag_v} !== {exp_n, exp_z, exp_v} || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_%0d: got res=%h nzv=%b%b%b ov%b want res=%h nzv=%b%b%b ov1",
                           i, result, flag_n, flag_z, flag_v, out_valid, exp_res, exp_n, exp_z, exp_v);
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (pulses !== 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses want 8", pulses);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int e, lo, ee;
    logic [2:0] op;
    logic [W-1:0] ra, rb, held;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
      model(op, ra, rb, ee);
      do_op(op, ra, rb, e, lo);
      n_tests++;
      if (result !== exp_res || {flag_n, flag_z, flag_v} !== {exp_n, exp_z, exp_v} || e !== ee || lo !== ee) begin
        n_fail++; $display("FAIL rand_%0d op%0d a=%h b=%h: got res=%h nzv=%b%b%b edges %0d low %0d want res=%h nzv=%b%b%b edges %0d",
                           i, op, ra, rb, result, flag_n, flag_z, flag_v, e, lo, exp_res, exp_n, exp_z, exp_v, ee);
      end
      held = result;
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0 || result !== held) begin
        n_fail++; $display("FAIL rand_hold_%0d: got ov%b res=%h want ov0 res=%h", i, out_valid, result, held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_xor();
    test_sra_latency();
    test_ror_sll();
    test_reset_during_shift();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
